pc_fetch: RTL and testbench

- Program-counter register and instruction-fetch sequencer. Sits directly downstream of the PC-select mux and consumes its 32-bit next-PC output.
- Owns the architectural PC and drives the instruction-memory request/response handshake. Presents one fetched instruction at a time to decode through a valid/ready buffer.
- Produces PC+4, which feeds back to the PC-select mux as the sequential (increment) address.

---
 rtl/pc_fetch_if.sv | 46 ++++
 rtl/pc_fetch.sv | 109 ++++++++++
 tb/tb_pc_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side handshake bundle for pc_fetch.
// It carries two channels:
//   - the instruction-memory request/response channel;
//   - the buffered-instruction valid/ready channel towards decode.
// The master modport is the fetch unit's view of the bundle.
// The slave modport is the view of memory and decode together.
interface pc_fetch_if #(
    parameter int WORD_SIZE = 32
);
    // Instruction-memory channel
    logic                 imem_req;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [WORD_SIZE-1:0] imem_rdata;

    // Decode channel
    logic                 inst_valid;
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] inst_pc;
    logic                 inst_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register plus instruction-fetch sequencer.
// The block runs one memory transaction at a time through three states.
//   REQ  : request presented.
//   WAIT : waiting for read data.
//   HOLD : instruction buffered for decode.
// A redirect (flush) replaces the PC at any point. A response that was
// already owed by memory for the old address is marked "killed" and is
// dropped when it arrives.
module pc_fetch #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] next_pc,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] flush_pc,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pc_plus4,
    pc_fetch_if.master           bus
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]           state;
    logic                 kill;
    logic                 inst_valid_q;
    logic [WORD_SIZE-1:0] inst_q;
    logic [WORD_SIZE-1:0] inst_pc_q;

    // Request is gated by reset, so nothing leaves the block while reset is held.
    always_comb begin
        bus.imem_req   = (state == S_REQ) && !reset;
        bus.imem_addr  = pc;
        bus.inst_valid = inst_valid_q;
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
        pc_plus4       = pc + WORD_SIZE'(4);
    end

    // Fetch sequencer: PC, kill flag and instruction buffer advance together.
    // NOTE: every register here uses non-blocking assignment. Several branches
    // read pc and kill while also updating them. They must all see the values
    // from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= S_REQ;
            kill         <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end
                    if (bus.imem_gnt) begin
                        // The granted request used the old pc, so a flush here
                        // has to mark the coming response as killed.
                        state <= S_WAIT;
                        if (flush) begin
                            kill <= 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end
                    if (bus.imem_rvalid) begin
                        if (kill || flush) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst_q       <= bus.imem_rdata;
                            inst_pc_q    <= pc;
                            inst_valid_q <= 1'b1;
                            state        <= S_HOLD;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (flush) begin
                        inst_valid_q <= 1'b0;
                        pc           <= flush_pc;
                        state        <= S_REQ;
                    end else if (bus.inst_ready) begin
                        inst_valid_q <= 1'b0;
                        pc           <= next_pc;
                        state        <= S_REQ;
                    end
                end

                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch.
// The bench uses two kinds of stimulus:
//   - a table of directed per-cycle vectors with hand-computed expected outputs;
//   - hand-written sequences for reset mid-transaction and for PC wrap-around.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int errors = 0;
    int checks = 0;

    pc_fetch_if #(.WORD_SIZE(32)) bus ();

    pc_fetch #(
        .WORD_SIZE (32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .next_pc  (next_pc),
        .flush    (flush),
        .flush_pc (flush_pc),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .bus      (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        flush;
        logic [31:0] fpc;
        logic [31:0] npc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // rvalid is only legal in WAIT, where neither imem_req nor inst_valid is high
    always @(negedge clk) begin
        if (bus.imem_rvalid === 1'b1) begin
            check("rvalid_protocol", {31'd0, bus.imem_req | bus.inst_valid}, 32'd0);
        end
    end

    task automatic drive(input logic f, input logic [31:0] fpc, input logic [31:0] npc,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy);
        flush           = f;
        flush_pc        = fpc;
        next_pc         = npc;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;
        bus.inst_ready  = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_pc,
                              input logic [31:0] e_p4, input logic e_valid,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc);
        @(negedge clk);
        check({tag, ".imem_req"},   {31'd0, bus.imem_req},   {31'd0, e_req});
        check({tag, ".imem_addr"},  bus.imem_addr,           e_pc);
        check({tag, ".pc"},         pc,                      e_pc);
        check({tag, ".pc_plus4"},   pc_plus4,                e_p4);
        check({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, e_valid});
        check({tag, ".inst"},       bus.inst,                e_inst);
        check({tag, ".inst_pc"},    bus.inst_pc,             e_ipc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic f, input logic [31:0] fpc, input logic [31:0] npc,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic rdy, input logic e_req, input logic [31:0] e_pc,
                                input logic [31:0] e_p4, input logic e_valid,
                                input logic [31:0] e_inst, input logic [31:0] e_ipc);
        vec_t v;
        v.flush = f;   v.fpc = fpc;     v.npc = npc;   v.gnt = gnt;
        v.rv = rv;     v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_pc = e_pc; v.e_p4 = e_p4; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_ipc = e_ipc;
        return v;
    endfunction

    initial begin
        // Columns: flush, flush_pc, next_pc, gnt, rvalid, rdata, ready |
        //          req, pc, pc_plus4, valid, inst, inst_pc (seen during that cycle)
        // Basic fetch: gnt at cycle 0, rvalid at 1, valid at 2, new pc at 3
        vecs[0]  = mk(0, 0, 0,      1, 0, 0,            0,  1, 32'h0,   32'h4,   0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 0,      0, 1, 32'h00500093, 0,  0, 32'h0,   32'h4,   0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 32'h4,  0, 0, 0,            1,  0, 32'h0,   32'h4,   1, 32'h00500093, 32'h0);
        vecs[3]  = mk(0, 0, 0,      1, 0, 0,            0,  1, 32'h4,   32'h8,   0, 32'h00500093, 32'h0);
        // Back-pressure: ready low for 5 cycles in HOLD
        vecs[4]  = mk(0, 0, 0,      0, 1, 32'h00A00113, 0,  0, 32'h4,   32'h8,   0, 32'h00500093, 32'h0);
        vecs[5]  = mk(0, 0, 32'h40, 0, 0, 0,            0,  0, 32'h4,   32'h8,   1, 32'h00A00113, 32'h4);
        vecs[6]  = mk(0, 0, 32'h40, 0, 0, 0,            0,  0, 32'h4,   32'h8,   1, 32'h00A00113, 32'h4);
        vecs[7]  = mk(0, 0, 32'h40, 0, 0, 0,            0,  0, 32'h4,   32'h8,   1, 32'h00A00113, 32'h4);
        vecs[8]  = mk(0, 0, 32'h40, 0, 0, 0,            0,  0, 32'h4,   32'h8,   1, 32'h00A00113, 32'h4);
        vecs[9]  = mk(0, 0, 32'h40, 0, 0, 0,            0,  0, 32'h4,   32'h8,   1, 32'h00A00113, 32'h4);
        vecs[10] = mk(0, 0, 32'h40, 0, 0, 0,            1,  0, 32'h4,   32'h8,   1, 32'h00A00113, 32'h4);
        // Flush in WAIT; the late response is discarded
        vecs[11] = mk(0, 0, 0,      1, 0, 0,            0,  1, 32'h40,  32'h44,  0, 32'h00A00113, 32'h4);
        vecs[12] = mk(1, 32'h100, 0, 0, 0, 0,           0,  0, 32'h40,  32'h44,  0, 32'h00A00113, 32'h4);
        vecs[13] = mk(0, 0, 0,      0, 0, 0,            0,  0, 32'h100, 32'h104, 0, 32'h00A00113, 32'h4);
        vecs[14] = mk(0, 0, 0,      0, 1, 32'hDEADBEEF, 0,  0, 32'h100, 32'h104, 0, 32'h00A00113, 32'h4);
        vecs[15] = mk(0, 0, 0,      1, 0, 0,            0,  1, 32'h100, 32'h104, 0, 32'h00A00113, 32'h4);
        // Flush wins over ready in HOLD
        vecs[16] = mk(0, 0, 0,      0, 1, 32'h00108093, 0,  0, 32'h100, 32'h104, 0, 32'h00A00113, 32'h4);
        vecs[17] = mk(1, 32'h200, 32'h8, 0, 0, 0,       1,  0, 32'h100, 32'h104, 1, 32'h00108093, 32'h100);
        vecs[18] = mk(0, 0, 0,      0, 0, 0,            0,  1, 32'h200, 32'h204, 0, 32'h00108093, 32'h100);
        // Flush in REQ: without grant, then with grant (response killed)
        vecs[19] = mk(1, 32'h300, 0, 0, 0, 0,           0,  1, 32'h200, 32'h204, 0, 32'h00108093, 32'h100);
        vecs[20] = mk(1, 32'h400, 0, 1, 0, 0,           0,  1, 32'h300, 32'h304, 0, 32'h00108093, 32'h100);
        vecs[21] = mk(0, 0, 0,      0, 1, 32'h11111111, 0,  0, 32'h400, 32'h404, 0, 32'h00108093, 32'h100);
        vecs[22] = mk(0, 0, 0,      0, 0, 0,            0,  1, 32'h400, 32'h404, 0, 32'h00108093, 32'h100);

        reset = 1'b1;
        idle();
        tick();
        expect_out("reset", 0, 32'h0, 32'h4, 0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].flush, vecs[i].fpc, vecs[i].npc, vecs[i].gnt,
                  vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_p4,
                       vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_ipc);
            tick();
        end

        // Reset while a transaction is outstanding, after a buffer fill
        drive(0, 0, 0, 1, 0, 0, 0);
        expect_out("rst_seq.req", 1, 32'h400, 32'h404, 0, 32'h00108093, 32'h100);
        tick();
        drive(0, 0, 0, 0, 1, 32'h00000513, 0);
        expect_out("rst_seq.wait", 0, 32'h400, 32'h404, 0, 32'h00108093, 32'h100);
        tick();
        drive(0, 0, 32'h500, 0, 0, 0, 1);
        expect_out("rst_seq.hold", 0, 32'h400, 32'h404, 1, 32'h00000513, 32'h400);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        expect_out("rst_seq.req2", 1, 32'h500, 32'h504, 0, 32'h00000513, 32'h400);
        tick();
        idle();
        reset = 1'b1;
        expect_out("rst_seq.in_wait", 0, 32'h500, 32'h504, 0, 32'h00000513, 32'h400);
        tick();
        expect_out("rst_seq.held", 0, 32'h0, 32'h4, 0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        expect_out("rst_seq.release", 1, 32'h0, 32'h4, 0, 32'h0, 32'h0);
        tick();

        // Flush to the top of the address space, then stall the grant
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        expect_out("wrap.flush", 1, 32'h0, 32'h4, 0, 32'h0, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            expect_out($sformatf("wrap.stall%0d", i), 1, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 32'h0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        expect_out("wrap.gnt", 1, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h00000013, 0);
        expect_out("wrap.wait", 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 32'h0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 0, 1);
        expect_out("wrap.hold", 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h00000013, 32'hFFFF_FFFC);
        tick();
        idle();
        expect_out("wrap.next", 1, 32'h0, 32'h4, 0, 32'h00000013, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
